// File: rtl/lzrw1_token_parser.sv
// LZRW1 stream parser: splits a compressed byte stream into literal/copy tokens for the decompressor.
// Define LZRW1_TOKEN_STATS_EN to add saturating literal/copy/error statistic counters.
module lzrw1_token_parser #(
  parameter int ITEMS_PER_GROUP = 16
`ifdef LZRW1_TOKEN_STATS_EN
  , parameter int COUNT_WIDTH = 32
`endif
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [15:0] token_data,
  output logic        token_is_copy,
  output logic        token_valid,
  input  logic        decompressor_busy,
`ifdef LZRW1_TOKEN_STATS_EN
  output logic                   format_error,
  output logic [COUNT_WIDTH-1:0] literal_count,
  output logic [COUNT_WIDTH-1:0] copy_count,
  output logic [COUNT_WIDTH-1:0] error_count
`else
  output logic        format_error
`endif
);

  localparam int CntW = $clog2(ITEMS_PER_GROUP);
  localparam logic [CntW-1:0] LastItem = CntW'(ITEMS_PER_GROUP - 1);

  typedef enum logic [2:0] {
    CTRL_LO,
    CTRL_HI,
    BYTE0,
    BYTE1,
    ISSUE,
    HOLDOFF
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     ctrl_q, ctrl_d;
  logic [CntW-1:0] item_cnt_q, item_cnt_d;
  logic [7:0]      hold_q, hold_d;
  logic [15:0]     data_q, data_d;
  logic            copy_q, copy_d;
  logic            last_q, last_d;
  logic            err_q, err_d;
  logic            accept;

  assign in_ready = !reset && (state_q == CTRL_LO || state_q == CTRL_HI ||
                               state_q == BYTE0   || state_q == BYTE1);
  assign accept        = in_valid && in_ready;
  assign token_valid   = (state_q == ISSUE) && !decompressor_busy;
  assign token_data    = data_q;
  assign token_is_copy = copy_q;
  assign format_error  = err_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= CTRL_LO;
      ctrl_q     <= '0;
      item_cnt_q <= '0;
      hold_q     <= '0;
      data_q     <= '0;
      copy_q     <= 1'b0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      item_cnt_q <= item_cnt_d;
      hold_q     <= hold_d;
      data_q     <= data_d;
      copy_q     <= copy_d;
      last_q     <= last_d;
      err_q      <= err_d;
    end
  end

  // Any malformed byte drops the partial item and restarts at a control word.
  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    item_cnt_d = item_cnt_q;
    hold_d     = hold_q;
    data_d     = data_q;
    copy_d     = copy_q;
    last_d     = last_q;
    err_d      = 1'b0;
    case (state_q)
      CTRL_LO: if (accept) begin
        if (in_last) begin
          err_d      = 1'b1;
          item_cnt_d = '0;
        end else begin
          ctrl_d[7:0] = in_byte;
          state_d     = CTRL_HI;
        end
      end
      CTRL_HI: if (accept) begin
        item_cnt_d = '0;
        if (in_last) begin
          err_d   = 1'b1;
          state_d = CTRL_LO;
        end else begin
          ctrl_d[15:8] = in_byte;
          state_d      = BYTE0;
        end
      end
      BYTE0: if (accept) begin
        if (ctrl_q[item_cnt_q]) begin
          if (in_last) begin
            err_d      = 1'b1;
            item_cnt_d = '0;
            state_d    = CTRL_LO;
          end else begin
            hold_d  = in_byte;
            state_d = BYTE1;
          end
        end else begin
          data_d  = {8'h00, in_byte};
          copy_d  = 1'b0;
          last_d  = in_last;
          state_d = ISSUE;
        end
      end
      BYTE1: if (accept) begin
        if (hold_q[7:4] == 4'd0) begin
          err_d      = 1'b1;
          item_cnt_d = '0;
          state_d    = CTRL_LO;
        end else begin
          data_d  = {hold_q, in_byte};
          copy_d  = 1'b1;
          last_d  = in_last;
          state_d = ISSUE;
        end
      end
      ISSUE: if (!decompressor_busy) state_d = HOLDOFF;
      // Busy is ignored here because the decompressor only raises it a cycle after taking a token.
      HOLDOFF: begin
        if (last_q) begin
          last_d     = 1'b0;
          item_cnt_d = '0;
          state_d    = CTRL_LO;
        end else if (item_cnt_q == LastItem) begin
          item_cnt_d = '0;
          state_d    = CTRL_LO;
        end else begin
          item_cnt_d = item_cnt_q + 1'b1;
          state_d    = BYTE0;
        end
      end
      default: state_d = CTRL_LO;
    endcase
  end

`ifdef LZRW1_TOKEN_STATS_EN
  logic [COUNT_WIDTH-1:0] lit_cnt_q, copy_cnt_q, err_cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      lit_cnt_q  <= '0;
      copy_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      if (token_valid && !copy_q && lit_cnt_q != '1)  lit_cnt_q  <= lit_cnt_q + 1'b1;
      if (token_valid && copy_q && copy_cnt_q != '1)  copy_cnt_q <= copy_cnt_q + 1'b1;
      if (err_q && err_cnt_q != '1)                   err_cnt_q  <= err_cnt_q + 1'b1;
    end
  end

  assign literal_count = lit_cnt_q;
  assign copy_count    = copy_cnt_q;
  assign error_count   = err_cnt_q;
`endif

endmodule

// File: tb/tb_lzrw1_token_parser.sv
// Directed bench for lzrw1_token_parser: token streams, busy stalls, group wrap, format errors, reset.
// Exercises the statistic counters too when LZRW1_TOKEN_STATS_EN is defined.
module tb_lzrw1_token_parser;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_byte = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [15:0] token_data;
  logic        token_is_copy;
  logic        token_valid;
  logic        decompressor_busy = 1'b0;
  logic        format_error;
`ifdef LZRW1_TOKEN_STATS_EN
  logic [31:0] literal_count, copy_count, error_count;
`endif

  int n_cmp = 0;
  int n_fail = 0;
  int timeouts = 0;
  int err_seen = 0;
  logic [16:0] tok_q[$];

  lzrw1_token_parser dut (
    .clock(clock),
    .reset(reset),
    .in_byte(in_byte),
    .in_valid(in_valid),
    .in_last(in_last),
    .in_ready(in_ready),
    .token_data(token_data),
    .token_is_copy(token_is_copy),
    .token_valid(token_valid),
    .decompressor_busy(decompressor_busy),
`ifdef LZRW1_TOKEN_STATS_EN
    .format_error(format_error),
    .literal_count(literal_count),
    .copy_count(copy_count),
    .error_count(error_count)
`else
    .format_error(format_error)
`endif
  );

  always #5 clock = ~clock;

  // Collect every issued token and error pulse, sampled mid-cycle.
  always @(negedge clock) begin
    if (token_valid) tok_q.push_back({token_is_copy, token_data});
    if (format_error) err_seen++;
  end

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; decompressor_busy = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    tok_q.delete();
    err_seen = 0;
    timeouts = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int waited;
    waited = 0;
    in_byte = b; in_last = last; in_valid = 1'b1;
    @(negedge clock);
    while (!in_ready && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    if (!in_ready) timeouts++;
    @(posedge clock); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    n_cmp++;
    if ({in_ready, token_valid, token_is_copy, format_error, token_data} !== 20'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got ready=%b valid=%b copy=%b err=%b data=%h, want all 0",
               in_ready, token_valid, token_is_copy, format_error, token_data);
    end
    do_reset();
    @(negedge clock);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reset_ready_after: got %b want 1", in_ready);
    end
  endtask

  task automatic test_basic_stream();
    do_reset();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h41, 1'b0);
    send_byte(8'h30, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h42, 1'b1);
    @(negedge clock);
    n_cmp++;
    if ({token_valid, token_is_copy, token_data} !== {1'b1, 1'b0, 16'h0042}) begin
      n_fail++;
      $display("[TB] FAIL basic_latency: got valid=%b copy=%b data=%h want 1/0/0042",
               token_valid, token_is_copy, token_data);
    end
    @(negedge clock);
    @(negedge clock);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL basic_back_to_ctrl: in_ready got %b want 1", in_ready);
    end
    idle(2);
    n_cmp++;
    if (tok_q.size() != 3 || timeouts != 0) begin
      n_fail++;
      $display("[TB] FAIL basic_count: got %0d tokens (timeouts %0d) want 3 (0)", tok_q.size(), timeouts);
    end else begin
      n_cmp++;
      if (tok_q[0] !== 17'h00041 || tok_q[1] !== 17'h13005 || tok_q[2] !== 17'h00042) begin
        n_fail++;
        $display("[TB] FAIL basic_tokens: got %h %h %h want 00041 13005 00042", tok_q[0], tok_q[1], tok_q[2]);
      end
    end
  endtask

  task automatic test_busy_stall();
    int bad;
    bad = 0;
    do_reset();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    decompressor_busy = 1'b1;
    send_byte(8'h41, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (token_valid !== 1'b0 || in_ready !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("[TB] FAIL busy_hold: %0d of 10 stalled cycles had valid/ready high, want 0", bad);
    end
    @(posedge clock); #1;
    decompressor_busy = 1'b0;
    @(negedge clock);
    n_cmp++;
    if ({token_valid, token_data} !== {1'b1, 16'h0041}) begin
      n_fail++;
      $display("[TB] FAIL busy_release: got valid=%b data=%h want 1/0041", token_valid, token_data);
    end
    @(posedge clock); #1;
    send_byte(8'h30, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h42, 1'b1);
    idle(4);
    n_cmp++;
    if (tok_q.size() != 3 || timeouts != 0) begin
      n_fail++;
      $display("[TB] FAIL busy_count: got %0d tokens want 3", tok_q.size());
    end else begin
      n_cmp++;
      if (tok_q[0] !== 17'h00041 || tok_q[1] !== 17'h13005 || tok_q[2] !== 17'h00042) begin
        n_fail++;
        $display("[TB] FAIL busy_tokens: got %h %h %h want 00041 13005 00042", tok_q[0], tok_q[1], tok_q[2]);
      end
    end
  endtask

  task automatic test_group_wrap();
    int bad;
    bad = 0;
    do_reset();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b1);
    idle(4);
    n_cmp++;
    if (tok_q.size() != 17 || timeouts != 0) begin
      n_fail++;
      $display("[TB] FAIL wrap_count: got %0d tokens want 17", tok_q.size());
    end else begin
      for (int i = 0; i < 16; i++) if (tok_q[i] !== {9'h000, i[7:0]}) bad++;
      n_cmp++;
      if (bad != 0) begin
        n_fail++;
        $display("[TB] FAIL wrap_literals: %0d of 16 literal tokens wrong, want 0", bad);
      end
      n_cmp++;
      if (tok_q[16] !== 17'h11234) begin
        n_fail++;
        $display("[TB] FAIL wrap_next_group: got %h want 11234", tok_q[16]);
      end
    end
  endtask

  task automatic test_zero_length();
    do_reset();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h10, 1'b0);
    @(negedge clock);
    n_cmp++;
    if ({format_error, token_valid} !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL zlen_pulse: got err=%b valid=%b want 1/0", format_error, token_valid);
    end
    @(negedge clock);
    n_cmp++;
    if (format_error !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL zlen_one_cycle: err got %b want 0", format_error);
    end
    @(posedge clock); #1;
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h55, 1'b1);
    idle(4);
    n_cmp++;
    if (tok_q.size() != 1 || err_seen != 1 || timeouts != 0) begin
      n_fail++;
      $display("[TB] FAIL zlen_recover: got %0d tokens %0d errors want 1 1", tok_q.size(), err_seen);
    end else begin
      n_cmp++;
      if (tok_q[0] !== 17'h00055) begin
        n_fail++;
        $display("[TB] FAIL zlen_token: got %h want 00055", tok_q[0]);
      end
    end
  endtask

  task automatic test_last_and_reset();
    do_reset();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b1);
    @(negedge clock);
    n_cmp++;
    if (format_error !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL ctrlhi_last: err got %b want 1", format_error);
    end
    @(posedge clock); #1;
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h66, 1'b1);
    idle(4);
    n_cmp++;
    if (tok_q.size() != 1 || timeouts != 0) begin
      n_fail++;
      $display("[TB] FAIL ctrlhi_recover: got %0d tokens want 1", tok_q.size());
    end else begin
      n_cmp++;
      if (tok_q[0] !== 17'h00066) begin
        n_fail++;
        $display("[TB] FAIL ctrlhi_token: got %h want 00066", tok_q[0]);
      end
    end
    do_reset();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h30, 1'b0);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    n_cmp++;
    if ({in_ready, token_valid, token_is_copy, format_error, token_data} !== 20'h0) begin
      n_fail++;
      $display("[TB] FAIL midreset_outputs: ready=%b valid=%b copy=%b err=%b data=%h want all 0",
               in_ready, token_valid, token_is_copy, format_error, token_data);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    tok_q.delete();
    idle(4);
    n_cmp++;
    if (tok_q.size() != 0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL midreset_quiet: got %0d tokens ready=%b want 0 tokens ready=1", tok_q.size(), in_ready);
    end
  endtask

`ifdef LZRW1_TOKEN_STATS_EN
  task automatic test_stats();
    do_reset();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h41, 1'b0);
    send_byte(8'h30, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h42, 1'b1);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h10, 1'b0);
    idle(4);
    n_cmp++;
    if (literal_count !== 32'd2 || copy_count !== 32'd1 || error_count !== 32'd1) begin
      n_fail++;
      $display("[TB] FAIL stats_counts: got lit=%0d copy=%0d err=%0d want 2 1 1",
               literal_count, copy_count, error_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_stream();
    test_busy_stall();
    test_group_wrap();
    test_zero_length();
    test_last_and_reset();
`ifdef LZRW1_TOKEN_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
